ibex_poly_div: RTL and testbench
================================

IBEX_POLY_DIV -- requirements
Module: ibex_poly_div

Interface
REQ-001 SHALL have parameter DW_A, default 32, meaning dividend and quotient width in bits.
REQ-002 SHALL have parameter DW_B, default 16, meaning divisor and remainder width in bits.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i, input, 1 bit: request valid.
REQ-006 SHALL have port ready_o, output, 1 bit: block can accept a request.
REQ-007 SHALL have port dividend_i, input, 32 bits: GF(2) dividend, bit k is the coefficient of x^k.
REQ-008 SHALL have port divisor_i, input, 16 bits: GF(2) divisor, same encoding.
REQ-009 SHALL have port valid_o, output, 1 bit: result valid.
REQ-010 SHALL have port ready_i, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port quotient_o, output, 32 bits: quotient q.
REQ-012 SHALL have port remainder_o, output, 16 bits: remainder r.
REQ-013 SHALL have port div_zero_o, output, 1 bit: the divisor was zero; qualified by valid_o.

Function
REQ-014 SHALL compute q and r with dividend = clmul(q, divisor) XOR r and deg(r) < deg(divisor), all arithmetic carry-less over GF(2).
REQ-015 SHALL implement the states IDLE, CALC and DONE.
REQ-016 SHALL drive ready_o = 1 only in IDLE and valid_o = 1 only in DONE.
REQ-017 SHALL accept a request on a clock edge where valid_i && ready_o; it then captures the operands and computes d = deg(divisor) using a leading-one detect.
REQ-018 SHALL, when the accepted divisor is nonzero, enter CALC and process one dividend bit per cycle, MSB first; each cycle yields one quotient bit, and the remainder is XOR-reduced by the aligned divisor.
REQ-019 SHALL run 32 CALC cycles when early exit is not compiled in, so valid_o rises 32 cycles after the acceptance edge regardless of d.
REQ-020 SHALL, on the last CALC cycle, go to DONE with quotient_o and remainder_o registered.
REQ-021 SHALL, for a zero divisor, go directly from acceptance to DONE, with valid_o one cycle after acceptance and outputs div_zero_o = 1, quotient_o = 0, remainder_o = dividend_i[15:0].
REQ-022 SHALL hold quotient_o, remainder_o, div_zero_o and valid_o stable in DONE while ready_i = 0.
REQ-023 SHALL leave DONE for IDLE on an edge where ready_i = 1; outputs return to 0 in IDLE.
REQ-024 SHALL ignore valid_i in CALC and DONE: no capture and no operand corruption.
REQ-025 SHALL make the result independent of dividend_i and divisor_i changes after acceptance.
REQ-026 SHALL produce the quotient in bits [31-d:0]; upper quotient bits are 0, and remainder bits [15:d] are 0.

Reset
REQ-027 SHALL, on rst_ni low at any time including mid-CALC, immediately force state IDLE, discard any in-flight operation, and clear the counter and working registers.
REQ-028 SHALL drive ready_o = 1 and valid_o, div_zero_o, quotient_o and remainder_o = 0 while in reset.
REQ-029 SHALL accept a request on the first edge after rst_ni deasserts.

Configuration
REQ-030 SHALL use macro IBEX_POLY_DIV_EARLY_EXIT_EN to control the CALC length.
REQ-031 SHALL, when IBEX_POLY_DIV_EARLY_EXIT_EN is defined, run CALC for 32-d cycles, so valid_o rises 32-d cycles after acceptance, between 17 and 32.
REQ-032 SHALL, when IBEX_POLY_DIV_EARLY_EXIT_EN is undefined, keep CALC fixed at 32 cycles.
REQ-033 SHALL give results that are identical in both builds.

Structure
REQ-034 SHALL place the state enum poly_div_state_e, the width constants POLY_DW_A = 32 and POLY_DW_B = 16, and the counter width in shared package ibex_poly_pkg, which the existing carry-less multiplier may also import.
REQ-035 SHALL implement the leading-one detect of the divisor as sub-module ibex_poly_lod16, which outputs d[3:0] and a zero flag.
REQ-036 SHALL keep the FSM, the iteration counter and the shifting working registers inside ibex_poly_div.

Verification
REQ-037 SHALL cover: dividend 0x00000007, divisor 0x0003 -> q=0x00000002, r=0x0001, div_zero_o=0, valid_o exactly 32 cycles after acceptance (macro off).
REQ-038 SHALL cover: dividend 0xDEADBEEF, divisor 0x0001 -> q=0xDEADBEEF, r=0x0000; with macro on, latency 32; dividend 0x00000005, divisor 0x8000 -> q=0, r=0x0005, latency 17.
REQ-039 SHALL cover: divisor 0x0000, dividend 0x12345678 -> div_zero_o=1, q=0, r=0x5678, valid_o 1 cycle after acceptance.
REQ-040 SHALL cover: result ready, ready_i held 0 for 5 cycles while valid_i pulses with new operands -> outputs stable, no acceptance, ready_o=0; ready_i=1 -> IDLE next cycle, then the new request is accepted.
REQ-041 SHALL cover: rst_ni pulsed low at CALC cycle 10 -> outputs 0 and ready_o=1 immediately; the next request (0x00000005 / 0x0003) returns q=0x3, r=0.
REQ-042 SHALL cover: 1000 random nonzero pairs a, b plus c with deg c < deg b, applied as dividend = clmul(a,b)^c -> q=a, r=c, in both macro builds.

Source files
------------

// File: rtl/ibex_poly_pkg.sv
// Shared definitions for the GF(2) polynomial datapath (divider and carry-less multiplier).
package ibex_poly_pkg;

  localparam int POLY_DW_A  = 32;
  localparam int POLY_DW_B  = 16;
  localparam int POLY_CNT_W = $clog2(POLY_DW_A);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } poly_div_state_e;

endpackage

// File: rtl/ibex_poly_lod16.sv
// Leading-one detect for a 16-bit polynomial: deg is the index of the highest set bit.
module ibex_poly_lod16 (
  input  logic [15:0] vec,
  output logic [3:0]  deg,
  output logic        zero
);

  // Later (higher) hits overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    deg = '0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) deg = 4'(i);
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/ibex_poly_div.sv
// Bit-serial GF(2) polynomial divider: dividend = q*divisor ^ r, deg(r) < deg(divisor).
// Optional macro IBEX_POLY_DIV_EARLY_EXIT_EN preloads deg(divisor) bits and shortens CALC to 32-d cycles.
module ibex_poly_div
  import ibex_poly_pkg::*;
#(
  parameter int DW_A = POLY_DW_A,
  parameter int DW_B = POLY_DW_B
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [DW_A-1:0] dividend_i,
  input  logic [DW_B-1:0] divisor_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [DW_A-1:0] quotient_o,
  output logic [DW_B-1:0] remainder_o,
  output logic            div_zero_o
);

  poly_div_state_e state_reg, state_next;

  logic [DW_A-1:0]       dsh_reg;
  logic [DW_B-1:0]       div_reg;
  logic [3:0]            d_reg;
  logic [DW_B-1:0]       r_reg;
  logic [DW_A-1:0]       q_reg;
  logic [POLY_CNT_W-1:0] cnt_reg;
  logic [DW_A-1:0]       quot_reg;
  logic [DW_B-1:0]       rem_reg;
  logic                  dz_reg;

  logic [3:0]            lod_d;
  logic                  lod_zero;

  logic [DW_B-1:0]       r_init;
  logic [DW_A-1:0]       dsh_init;
  logic [POLY_CNT_W-1:0] cnt_init;

  logic [DW_B-1:0]       t_shift;
  logic                  q_bit;
  logic [DW_B-1:0]       r_step;
  logic [DW_A-1:0]       q_step;

  ibex_poly_lod16 u_lod (
    .vec  (divisor_i),
    .deg  (lod_d),
    .zero (lod_zero)
  );

  // The top d dividend bits can never produce a quotient bit, so they may seed the remainder.
  always_comb begin
`ifdef IBEX_POLY_DIV_EARLY_EXIT_EN
    r_init   = DW_B'(dividend_i >> (DW_A - int'(lod_d)));
    dsh_init = dividend_i << lod_d;
    cnt_init = POLY_CNT_W'(DW_A - 1 - int'(lod_d));
`else
    r_init   = '0;
    dsh_init = dividend_i;
    cnt_init = POLY_CNT_W'(DW_A - 1);
`endif
  end

  // deg(r) < d holds before the shift, so r_reg's MSB is always zero and t_shift fits.
  always_comb begin
    t_shift = {r_reg[DW_B-2:0], dsh_reg[DW_A-1]};
    q_bit   = t_shift[d_reg];
    r_step  = q_bit ? (t_shift ^ div_reg) : t_shift;
    q_step  = {q_reg[DW_A-2:0], q_bit};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_next = lod_zero ? DONE : CALC;
      end
      CALC: begin
        if (cnt_reg == '0) state_next = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dsh_reg  <= '0;
      div_reg  <= '0;
      d_reg    <= '0;
      r_reg    <= '0;
      q_reg    <= '0;
      cnt_reg  <= '0;
      quot_reg <= '0;
      rem_reg  <= '0;
      dz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            div_reg <= divisor_i;
            d_reg   <= lod_d;
            q_reg   <= '0;
            r_reg   <= r_init;
            dsh_reg <= dsh_init;
            cnt_reg <= cnt_init;
            if (lod_zero) begin
              quot_reg <= '0;
              rem_reg  <= dividend_i[DW_B-1:0];
              dz_reg   <= 1'b1;
            end
          end
        end
        CALC: begin
          dsh_reg <= dsh_reg << 1;
          r_reg   <= r_step;
          q_reg   <= q_step;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            quot_reg <= q_step;
            rem_reg  <= r_step;
            dz_reg   <= 1'b0;
          end
        end
        DONE: begin
          if (ready_i) begin
            quot_reg <= '0;
            rem_reg  <= '0;
            dz_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_o  = quot_reg;
  assign remainder_o = rem_reg;
  assign div_zero_o  = dz_reg;

endmodule

// File: tb/tb_ibex_poly_div.sv
// Directed and constructed-random checks of ibex_poly_div using a result scoreboard.
module tb_ibex_poly_div;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [15:0] divisor_i = '0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] quotient_o;
  logic [15:0] remainder_o;
  logic        div_zero_o;

  int n_asserts = 0;
  int n_fails   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

  ibex_poly_div dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clmul(input logic [31:0] a, input logic [15:0] b);
    logic [31:0] p = '0;
    for (int i = 0; i < 16; i++) if (b[i]) p ^= a << i;
    return p;
  endfunction

  function automatic int deg16(input logic [15:0] b);
    int d = 0;
    for (int i = 0; i < 16; i++) if (b[i]) d = i;
    return d;
  endfunction

  // Edges after the acceptance edge until valid_o is visible (0: visible in the very next cycle).
  function automatic int exp_lat(input logic [15:0] b);
    if (b == 16'h0) return 0;
`ifdef IBEX_POLY_DIV_EARLY_EXIT_EN
    return 32 - deg16(b);
`else
    return 32;
`endif
  endfunction

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic start(input logic [31:0] a, input logic [15:0] b,
                       input logic [31:0] q, input logic [15:0] r, input logic dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz; e.lat = 8'(exp_lat(b));
    sb.push_back(e);
    chk("ready_before_accept", 64'(ready_o), 64'(1'b1));
    dividend_i = a;
    divisor_i  = b;
    valid_i    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i    = 1'b0;
    dividend_i = $urandom;
    divisor_i  = 16'($urandom);
  endtask

  task automatic finish_txn(input string tag, input bit release_it);
    int   cyc = 0;
    exp_t e;
    while (valid_o !== 1'b1 && cyc < 100) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
    end
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'(sb.size()), 64'(1));
      return;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_quotient"}, 64'(quotient_o), 64'(e.q));
    chk({tag, "_remainder"}, 64'(remainder_o), 64'(e.r));
    chk({tag, "_div_zero"}, 64'(div_zero_o), 64'(e.dz));
    $display("txn %s: dividend=%08h divisor=%04h q=%08h r=%04h dz=%0d lat=%0d",
             tag, e.a, e.b, quotient_o, remainder_o, div_zero_o, cyc);
    if (release_it) begin
      ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      ready_i = 1'b0;
      chk({tag, "_idle_ready"}, 64'(ready_o), 64'(1'b1));
      chk({tag, "_idle_valid"}, 64'(valid_o), 64'(1'b0));
      chk({tag, "_idle_quotient"}, 64'(quotient_o), 64'(0));
    end
  endtask

  initial begin
    logic [31:0] a, mask, c32;
    logic [15:0] b, c;
    int          db;

    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(ready_o), 64'(1'b1));
    chk("rst_valid", 64'(valid_o), 64'(1'b0));
    chk("rst_outputs", 64'({quotient_o, remainder_o, div_zero_o}), 64'(0));
    rst_ni = 1'b1;

    // Accepted on the first edge after reset release.
    start(32'h0000_0007, 16'h0003, 32'h0000_0002, 16'h0001, 1'b0);
    finish_txn("x2x1_by_x1", 1'b1);
    start(32'hDEAD_BEEF, 16'h0001, 32'hDEAD_BEEF, 16'h0000, 1'b0);
    finish_txn("by_one", 1'b1);
    start(32'h0000_0005, 16'h8000, 32'h0000_0000, 16'h0005, 1'b0);
    finish_txn("by_x15", 1'b1);
    start(32'h1234_5678, 16'h0000, 32'h0000_0000, 16'h5678, 1'b1);
    finish_txn("div_zero", 1'b1);

    // Back-pressure: result held while new requests are offered and ignored.
    start(32'h0000_0007, 16'h0003, 32'h0000_0002, 16'h0001, 1'b0);
    finish_txn("stall", 1'b0);
    for (int i = 0; i < 5; i++) begin
      valid_i    = ~valid_i;
      dividend_i = clmul(32'h15, 16'h7) ^ 32'h1;
      divisor_i  = 16'h0007;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("stall_valid", 64'(valid_o), 64'(1'b1));
      chk("stall_ready", 64'(ready_o), 64'(1'b0));
      chk("stall_hold", 64'({quotient_o, remainder_o, div_zero_o}), {15'h0, 32'h2, 16'h1, 1'b0});
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("stall_release_ready", 64'(ready_o), 64'(1'b1));
    chk("stall_release_valid", 64'(valid_o), 64'(1'b0));
    start(clmul(32'h15, 16'h7) ^ 32'h1, 16'h0007, 32'h15, 16'h1, 1'b0);
    finish_txn("after_stall", 1'b1);

    // Reset in the middle of CALC aborts the operation.
    dividend_i = 32'hDEAD_BEEF;
    divisor_i  = 16'h0003;
    valid_i    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready_o), 64'(1'b1));
    chk("midrst_valid", 64'(valid_o), 64'(1'b0));
    chk("midrst_outputs", 64'({quotient_o, remainder_o, div_zero_o}), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    start(32'h0000_0005, 16'h0003, 32'h0000_0003, 16'h0000, 1'b0);
    finish_txn("after_reset", 1'b1);

    // Constructed random: dividend = a*b ^ c with deg(c) < deg(b) and a*b within 32 bits.
    for (int n = 0; n < 1000; n++) begin
      b    = 16'($urandom_range(1, 65535));
      db   = deg16(b);
      mask = 32'hFFFF_FFFF >> db;
      a    = $urandom & mask;
      if (a == 32'h0) a = 32'h1;
      c32  = (db == 0) ? 32'h0 : ($urandom & ((32'h1 << db) - 32'h1));
      c    = c32[15:0];
      start(clmul(a, b) ^ {16'h0, c}, b, a, c, 1'b0);
      finish_txn("random", 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
